// File: rtl/axi_dma_rd.sv
// AXI4 read DMA: fetches num_trans 32-bit words from DRAM in INCR bursts of at most
// 256 beats and streams them, in address order, to an on-chip feature-map buffer.
module axi_dma_rd #(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,
    output logic [AXI_WIDTH_AD-1:0] M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic [AXI_WIDTH_ID-1:0] M_ARID,
    output logic [1:0]              M_ARLOCK,
    output logic [3:0]              M_ARCACHE,
    output logic [2:0]              M_ARPROT,
    output logic [3:0]              M_ARREGION,
    output logic [3:0]              M_ARUSER,
    output logic [3:0]              M_ARQOS,
    input  logic                    M_RVALID,
    output logic                    M_RREADY,
    input  logic [AXI_WIDTH_DA-1:0] M_RDATA,
    input  logic                    M_RLAST,
    input  logic [1:0]              M_RRESP,
    input  logic [AXI_WIDTH_ID-1:0] M_RID,
    input  logic                    M_RUSER,
    input  logic                    ap_start,
    output logic                    ap_done,
    input  logic [BITS_TRANS-1:0]   num_trans,
    input  logic [AXI_WIDTH_AD-1:0] mem_start_addr,
    input  logic                    out_ready,
    output logic [AXI_WIDTH_DA-1:0] out_data,
    output logic                    out_data_vld,
    output logic                    fail_check
);

    localparam int FIXED_BURST_SIZE = 256;

    typedef enum logic [1:0] {RD_IDLE, RD_PRE, RD_START, RD_SEQ} rd_state_t;

    rd_state_t               state_q, state_d;
    logic [BITS_TRANS-1:0]   num_trans_d;
    logic [BITS_TRANS-1:0]   burst_cnt;
    logic [BITS_TRANS-1:0]   remaining;
    logic [AXI_WIDTH_AD-1:0] addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic                    err_q;
    logic                    r_hs;
    logic                    burst_end;
    logic                    rresp_err;
    logic                    unused_inputs;

    assign M_ARSIZE   = 3'b010;
    assign M_ARBURST  = 2'b01;
    assign M_ARID     = '0;
    assign M_ARLOCK   = 2'b00;
    assign M_ARCACHE  = 4'b0000;
    assign M_ARPROT   = 3'b000;
    assign M_ARREGION = 4'b0000;
    assign M_ARUSER   = 4'b0000;
    assign M_ARQOS    = 4'b1111;
    assign M_ARADDR   = addr_q;
    assign M_ARLEN    = len_q;

    assign unused_inputs = ^{M_RID, M_RUSER};

    // R handshake is derived directly from state so it does not loop through M_RREADY
    assign r_hs      = M_RVALID && out_ready && (state_q == RD_SEQ);
    assign burst_end = r_hs && (beat_cnt == len_q);
    assign rresp_err = (M_RRESP != 2'b00);
    assign remaining = num_trans_d - burst_cnt;

    always_comb begin
        state_d   = state_q;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        ap_done   = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (ap_start) state_d = RD_PRE;
            end
            RD_PRE: begin
                if (burst_cnt == num_trans_d) begin
                    ap_done = 1'b1;
                    state_d = RD_IDLE;
                end else begin
                    state_d = RD_START;
                end
            end
            RD_START: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) state_d = RD_SEQ;
            end
            RD_SEQ: begin
                M_RREADY = out_ready;
                if (burst_end) state_d = RD_PRE;
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= RD_IDLE;
            num_trans_d  <= '0;
            burst_cnt    <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt     <= '0;
            err_q        <= 1'b0;
            out_data     <= '0;
            out_data_vld <= 1'b0;
            fail_check   <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_data_vld <= r_hs;
            // A missing RLAST on the final beat is treated like an error response
            fail_check   <= burst_end && (err_q || rresp_err || !M_RLAST);
            if (r_hs) out_data <= M_RDATA;
            case (state_q)
                RD_IDLE: begin
                    if (ap_start) begin
                        num_trans_d <= num_trans;
                        addr_q      <= mem_start_addr;
                        burst_cnt   <= '0;
                    end
                end
                RD_PRE: begin
                    if (burst_cnt != num_trans_d)
                        len_q <= (remaining >= BITS_TRANS'(FIXED_BURST_SIZE)) ?
                                 8'd255 : 8'(remaining - BITS_TRANS'(1));
                end
                RD_START: begin
                    if (M_ARREADY) beat_cnt <= '0;
                end
                RD_SEQ: begin
                    if (burst_end) begin
                        burst_cnt <= burst_cnt + BITS_TRANS'(len_q) + BITS_TRANS'(1);
                        addr_q    <= addr_q + ((AXI_WIDTH_AD'(len_q) + AXI_WIDTH_AD'(1)) << 2);
                        beat_cnt  <= '0;
                        err_q     <= 1'b0;
                    end else if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        // An early RLAST does not end the burst but marks it bad
                        err_q    <= err_q || rresp_err || M_RLAST;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
